// File: rtl/pour_pkg.sv
// Shared types and constants for the pour sequencer.
package pour_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPour,
    StSettle,
    StDone
  } pour_state_e;

  localparam int unsigned DRINK_MAX = 2;
  localparam int unsigned UNITS_W   = 4;

endpackage

// File: rtl/pour_sequencer_if.sv
// Request/status bundle between the order logic (master) and the pour sequencer (slave).
interface pour_sequencer_if;
  import pour_pkg::*;

  logic               start;
  logic [1:0]         drink;
  logic [UNITS_W-1:0] units;
  logic               abort;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               err;
  logic               servo_en;
  logic [1:0]         servo_sel;

  modport master (
    output start, drink, units, abort,
    input  busy, done, aborted, err, servo_en, servo_sel
  );

  modport slave (
    input  start, drink, units, abort,
    output busy, done, aborted, err, servo_en, servo_sel
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_CYCLES clocks, restartable via clear.
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PreW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PreW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == PreW'(TICK_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + PreW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pour_sequencer.sv
// Runs one timed pour on the servo PWM path, then a closing settle, then a done pulse.
module pour_sequencer
  import pour_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = 1_000_000,
  parameter int unsigned UNIT_TICKS   = 100,
  parameter int unsigned SETTLE_TICKS = 50
) (
  input  logic             clk,
  input  logic             rst,
  pour_sequencer_if.slave  bus
);

  localparam int unsigned TickMax = (UNIT_TICKS > SETTLE_TICKS) ? UNIT_TICKS : SETTLE_TICKS;
  localparam int unsigned TickW   = $clog2(TickMax + 1);

  pour_state_e        state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [UNITS_W-1:0] unit_q, unit_d;
  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic               flag_q, flag_d;
  logic               err_q, err_d;
  logic               en_q, busy_q, done_q, aborted_q;
  logic               tick, clear, legal;

  assign legal = (bus.drink <= 2'(DRINK_MAX)) && (bus.units != '0);
  // Prescaler restarts whenever the state changes so each phase starts on a full tick.
  assign clear = (state_d != state_q);

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    unit_d     = unit_q;
    tick_cnt_d = tick_cnt_q;
    flag_d     = flag_q;
    err_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (legal) begin
            state_d = StPour;
            sel_d   = bus.drink;
            unit_d  = bus.units;
            flag_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StPour: begin
        // Abort wins over a coincident terminal count so the pour is still reported as cut.
        if (bus.abort) begin
          state_d = StSettle;
          flag_d  = 1'b1;
        end else if (tick) begin
          if (tick_cnt_q == TickW'(UNIT_TICKS - 1)) begin
            tick_cnt_d = '0;
            unit_d     = unit_q - UNITS_W'(1);
            if (unit_q == UNITS_W'(1)) state_d = StSettle;
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end
      StSettle: begin
        if (tick) begin
          if (tick_cnt_q == TickW'(SETTLE_TICKS - 1)) state_d = StDone;
          else tick_cnt_d = tick_cnt_q + TickW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        sel_d   = '0;
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) tick_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      unit_q     <= '0;
      tick_cnt_q <= '0;
      flag_q     <= 1'b0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      unit_q     <= unit_d;
      tick_cnt_q <= tick_cnt_d;
      flag_q     <= flag_d;
      err_q      <= err_d;
      en_q       <= (state_d == StPour);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
      aborted_q  <= (state_d == StDone) && flag_d;
    end
  end

  assign bus.servo_en  = en_q;
  assign bus.servo_sel = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pour_sequencer.sv
// Directed bench for pour_sequencer with short tick/unit/settle lengths.
module tb_pour_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pour_sequencer_if bus ();

  pour_sequencer #(
    .TICK_CYCLES (4),
    .UNIT_TICKS  (2),
    .SETTLE_TICKS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples with servo_en high, counting from the current sample.
  task automatic count_high(output int n);
    n = 0;
    while (bus.servo_en === 1'b1 && n < 300) begin
      n++;
      step();
    end
  endtask

  // Samples before done rises, counting from the current sample.
  task automatic count_until_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 300) begin
      n++;
      step();
    end
  endtask

  task automatic request(input logic [1:0] d, input logic [3:0] u);
    bus.start = 1'b1;
    bus.drink = d;
    bus.units = u;
    step();
    bus.start = 1'b0;
  endtask

  // Checks high time, settle length, done/aborted and busy release of a running pour.
  task automatic finish_pour(input string tag, input int exp_high, input logic exp_abt);
    int n;
    count_high(n);
    check_eq({tag, "_high"}, n, exp_high);
    count_until_done(n);
    check_eq({tag, "_settle"}, n, 12);
    check_eq({tag, "_aborted"}, bus.aborted, exp_abt);
    check_eq({tag, "_busy_at_done"}, bus.busy, 1);
    step();
    check_eq({tag, "_done_1cyc"}, bus.done, 0);
    check_eq({tag, "_busy_fall"}, bus.busy, 0);
    check_eq({tag, "_sel_clr"}, bus.servo_sel, 0);
  endtask

  initial begin
    int n;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.drink = '0;
    bus.units = '0;
    bus.abort = 1'b0;
    #1;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_en", bus.servo_en, 0);
    check_eq("rst_sel", bus.servo_sel, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_err", bus.err, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Nominal pour
    request(2'd1, 4'd2);
    check_eq("nom_busy", bus.busy, 1);
    check_eq("nom_en", bus.servo_en, 1);
    check_eq("nom_sel", bus.servo_sel, 1);
    finish_pour("nom", 16, 1'b0);

    // Illegal requests
    request(2'd3, 4'd2);
    check_eq("ill_drink_err", bus.err, 1);
    check_eq("ill_drink_busy", bus.busy, 0);
    check_eq("ill_drink_en", bus.servo_en, 0);
    step();
    check_eq("ill_err_pulse", bus.err, 0);
    request(2'd0, 4'd0);
    check_eq("ill_units_err", bus.err, 1);
    check_eq("ill_units_busy", bus.busy, 0);
    check_eq("ill_units_en", bus.servo_en, 0);
    step();
    check_eq("ill_units_pulse", bus.err, 0);

    // Abort after 6 cycles of POUR
    request(2'd0, 4'd5);
    for (int i = 0; i < 5; i++) step();
    check_eq("abt_en_pre", bus.servo_en, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_eq("abt_en_fall", bus.servo_en, 0);
    check_eq("abt_busy", bus.busy, 1);
    finish_pour("abt", 0, 1'b1);

    // Start during POUR ignored, then back-to-back start when busy falls
    request(2'd1, 4'd1);
    step();
    step();
    request(2'd2, 4'd3);
    check_eq("ign_sel", bus.servo_sel, 1);
    check_eq("ign_err", bus.err, 0);
    finish_pour("ign", 5, 1'b0);
    request(2'd2, 4'd1);
    check_eq("b2b_busy", bus.busy, 1);
    check_eq("b2b_en", bus.servo_en, 1);
    check_eq("b2b_sel", bus.servo_sel, 2);
    finish_pour("b2b", 8, 1'b0);

    // Reset mid-POUR
    request(2'd1, 4'd3);
    step();
    step();
    rst = 1'b1;
    #1;
    check_eq("mid_rst_en", bus.servo_en, 0);
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_sel", bus.servo_sel, 0);
    step();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done === 1'b1) n++;
    end
    check_eq("mid_rst_no_done", n, 0);
    request(2'd1, 4'd2);
    check_eq("post_rst_sel", bus.servo_sel, 1);
    finish_pour("post_rst", 16, 1'b0);

    // Max length
    request(2'd0, 4'd15);
    finish_pour("max", 120, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
